// File: rtl/mem_map_pkg.sv
// Address map shared by the data-side memory responder and its FIFO.
// Holds the I/O page default, register offsets inside that page, STATUS
// bit positions, the region-select enum and the address decode helper.
package mem_map_pkg;

  localparam logic [15:0] MMIO_PAGE_DEFAULT = 16'hFFFF;

  localparam logic [15:0] CYCLE_OFS  = 16'h0000;
  localparam logic [15:0] LED_OFS    = 16'h0004;
  localparam logic [15:0] TXDATA_OFS = 16'h0008;
  localparam logic [15:0] STATUS_OFS = 16'h000C;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_OVF_BIT   = 8;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_CYCLE,
    REG_LED,
    REG_TX,
    REG_STATUS,
    REG_NONE
  } region_e;

  // Byte-lane bits [1:0] never take part in the decode.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [15:0] page);
    region_e r;
    if (addr[31:16] != page) begin
      r = REG_RAM;
    end else begin
      case ({addr[15:2], 2'b00})
        CYCLE_OFS:  r = REG_CYCLE;
        LED_OFS:    r = REG_LED;
        TXDATA_OFS: r = REG_TX;
        STATUS_OFS: r = REG_STATUS;
        default:    r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the transmit drain port.
// Ports: clk, reset (async, active-low), push/push_data (write side),
// pop (caller guarantees it only pops a valid head), full, empty,
// count (0..FIFO_DEPTH), head (oldest byte, 0 when empty).
// A push while full is still taken when a pop happens in the same cycle:
// the popped slot is exactly the one the write pointer lands on.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [7:0]                    head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; head is masked to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory responder for the pipelined MIPS core.
// Ports: clk, reset (async, active-low); core side memwrite/addr/writedata
// with combinational readdata; leds (LED register); tx_valid/tx_data/tx_ready
// drain port toward an external byte sink.
// Drain handshake: tx_valid is high whenever the FIFO holds a byte and
// tx_data is the oldest byte; a byte is consumed on any rising clk where
// tx_valid && tx_ready, and tx_data holds stable while tx_valid && !tx_ready.
module dmem_mmio
  import mem_map_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] MMIO_PAGE  = MMIO_PAGE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  leds,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  region_e          region;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      cycle;
  logic             ovf;
  logic             push;
  logic             pop;
  logic             overflow;
  logic             ovf_clear;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      status;
  logic             unused_bits;

  assign region  = decode_region(addr, MMIO_PAGE);
  assign ram_idx = addr[RAM_AW+1:2];   // upper bits alias the RAM

  assign push      = memwrite && (region == REG_TX);
  assign pop       = tx_valid && tx_ready;
  assign overflow  = push && fifo_full && !pop;
  assign ovf_clear = memwrite && (region == REG_STATUS) && writedata[STATUS_OVF_BIT];

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (writedata[7:0]),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (tx_data)
  );

  assign tx_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (memwrite && (region == REG_RAM)) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
      leds  <= '0;
      ovf   <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (memwrite && (region == REG_LED)) leds <= writedata[7:0];
      // An overflow in the clearing cycle keeps the flag set.
      if (overflow)       ovf <= 1'b1;
      else if (ovf_clear) ovf <= 1'b0;
    end
  end

  always_comb begin
    status                                = '0;
    status[STATUS_FULL_BIT]               = fifo_full;
    status[STATUS_EMPTY_BIT]              = fifo_empty;
    status[STATUS_COUNT_LSB +: CW]        = fifo_count;
    status[STATUS_OVF_BIT]                = ovf;
  end

  always_comb begin
    readdata = '0;
    case (region)
      REG_RAM:    readdata = ram[ram_idx];
      REG_CYCLE:  readdata = cycle;
      REG_LED:    readdata = {24'b0, leds};
      REG_STATUS: readdata = status;
      default:    readdata = '0;
    endcase
  end

  assign unused_bits = &{1'b0, addr[1:0], writedata[31:9]};

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio with a queue/array reference model.
module tb_dmem_mmio;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'hFFFF_0000;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  leds;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  // reference model state
  logic [31:0] m_ram [64];
  bit          m_ram_ok [64];
  logic [31:0] m_cycle = '0;
  logic [7:0]  m_leds = '0;
  logic        m_ovf = 1'b0;
  logic [7:0]  exp_q [$];
  bit          m_pop;

  dmem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .leds      (leds),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: inputs change 1 time unit after posedge, so they are stable here
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cycle = '0;
      m_leds  = '0;
      m_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      m_pop = (exp_q.size() != 0) && tx_ready;
      if (m_pop) void'(exp_q.pop_front());
      if (memwrite) begin
        if (addr[31:16] != 16'hFFFF) begin
          m_ram[addr[7:2]]    = writedata;
          m_ram_ok[addr[7:2]] = 1'b1;
        end else begin
          case ({addr[15:2], 2'b00})
            16'h0004: m_leds = writedata[7:0];
            16'h0008: begin
              if (exp_q.size() < DEPTH) exp_q.push_back(writedata[7:0]);
              else m_ovf = 1'b1;
            end
            16'h000C: if (writedata[8]) m_ovf = 1'b0;
            default: ;
          endcase
        end
      end
      m_cycle = m_cycle + 32'd1;
    end
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(exp_q.size()) << 2;
    if (exp_q.size() == DEPTH) s = s | 32'h1;
    if (exp_q.size() == 0)     s = s | 32'h2;
    if (m_ovf)                 s = s | 32'h100;
    return s;
  endfunction

  function automatic bit rd_known(input logic [31:0] a);
    return (a[31:16] == 16'hFFFF) || m_ram_ok[a[7:2]];
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a[31:16] != 16'hFFFF) return m_ram[a[7:2]];
    case ({a[15:2], 2'b00})
      16'h0000: return m_cycle;
      16'h0004: return {24'b0, m_leds};
      16'h000C: return exp_status();
      default:  return 32'h0;
    endcase
  endfunction

  // compare process: every negedge, all outputs against the model
  always @(negedge clk) begin
    check("leds", {24'b0, leds}, {24'b0, m_leds});
    check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
    check("tx_data", {24'b0, tx_data}, (exp_q.size() != 0) ? {24'b0, exp_q[0]} : 32'h0);
    if (rd_known(addr)) check("readdata", readdata, exp_read(addr));
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1'b1;
    cyc();
    memwrite = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    #1;
    check(name, readdata, e);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    rd_check("reset_cycle", 32'hFFFF_0000, 32'h0);
    check("reset_leds", {24'b0, leds}, 32'h0);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("reset_tx_data", {24'b0, tx_data}, 32'h0);

    @(posedge clk);
    #3 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rd_check("cycle_10", 32'hFFFF_0000, 32'd10);

    // RAM, aliasing, read-during-write
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_check("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_check("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    cyc();
    addr = 32'h0000_0010;
    writedata = 32'hCAFE_F00D;
    memwrite = 1'b1;
    #1;
    check("ram_rdw_old", readdata, 32'hDEAD_BEEF);
    cyc();
    memwrite = 1'b0;
    rd_check("ram_rdw_new", 32'h0000_0010, 32'hCAFE_F00D);

    // LED and unmapped offset
    wr(32'hFFFF_0004, 32'h1234_5678);
    check("leds_val", {24'b0, leds}, 32'h78);
    rd_check("led_rd", 32'hFFFF_0004, 32'h78);
    wr(32'hFFFF_0020, 32'hFFFF_FFFF);
    check("leds_kept", {24'b0, leds}, 32'h78);
    rd_check("unmapped_rd", 32'hFFFF_0020, 32'h0);
    rd_check("txdata_rd", 32'hFFFF_0008, 32'h0);

    // FIFO fill, overflow, clear, drain
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(32'hFFFF_0008, 32'h41 + 32'(i));
    rd_check("status_full", 32'hFFFF_000C, 32'h11);
    wr(32'hFFFF_0008, 32'h45);
    rd_check("status_ovf", 32'hFFFF_000C, 32'h111);
    wr(32'hFFFF_000C, 32'h100);
    rd_check("status_clr", 32'hFFFF_000C, 32'h11);
    tx_ready = 1'b1;
    #1;
    check("drain_0", {24'b0, tx_data}, 32'h41);
    for (int i = 1; i < 4; i++) begin
      cyc();
      check("drain_n", {24'b0, tx_data}, 32'h41 + 32'(i));
    end
    cyc();
    check("drain_done", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) wr(32'hFFFF_0008, 32'h61 + 32'(i));
    addr = 32'hFFFF_0008;
    writedata = 32'h55;
    memwrite = 1'b1;
    tx_ready = 1'b1;
    cyc();
    memwrite = 1'b0;
    tx_ready = 1'b0;
    rd_check("status_pushpop", 32'hFFFF_000C, 32'h11);
    tx_ready = 1'b1;
    #1;
    check("pp_0", {24'b0, tx_data}, 32'h62);
    cyc();
    check("pp_1", {24'b0, tx_data}, 32'h63);
    cyc();
    check("pp_2", {24'b0, tx_data}, 32'h64);
    cyc();
    check("pp_3", {24'b0, tx_data}, 32'h55);
    cyc();
    check("pp_done", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // backpressure
    wr(32'hFFFF_0008, 32'h99);
    repeat (5) begin
      check("bp_valid", {31'b0, tx_valid}, 32'h1);
      check("bp_data", {24'b0, tx_data}, 32'h99);
      cyc();
    end
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    check("bp_popped", {31'b0, tx_valid}, 32'h0);

    // randomized traffic, with occasional async reset pulses
    for (int i = 0; i < 2000; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: addr = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom)};
        4:          addr = 32'hFFFF_0000;
        5:          addr = 32'hFFFF_0004;
        6, 7:       addr = 32'hFFFF_0008;
        8:          addr = 32'hFFFF_000C;
        default:    addr = {16'hFFFF, 16'($urandom_range(0, 15) << 2)};
      endcase
      memwrite  = ($urandom_range(0, 2) != 0);
      writedata = $urandom;
      tx_ready  = ($urandom_range(0, 3) == 0);
      if ((i % 500) == 250) begin
        #2 reset = 1'b0;
        #4 reset = 1'b1;
      end
      cyc();
    end
    memwrite = 1'b0;
    tx_ready = 1'b0;

    // async reset in the middle of a drain
    wr(32'hFFFF_0004, 32'hA5);
    wr(32'hFFFF_0008, 32'h01);
    wr(32'hFFFF_0008, 32'h02);
    tx_ready = 1'b1;
    addr = 32'hFFFF_0000;
    #2 reset = 1'b0;
    #1;
    check("arst_cycle", readdata, 32'h0);
    check("arst_leds", {24'b0, leds}, 32'h0);
    check("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("arst_tx_data", {24'b0, tx_data}, 32'h0);
    @(posedge clk);
    #3 reset = 1'b1;
    tx_ready = 1'b0;
    cyc();
    check("arst_discard", {31'b0, tx_valid}, 32'h0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory responder for the pipelined MIPS core. It serves the core's data port: memory-stage address, write data and write strobe in; read data out.
- Contains a word-addressed data RAM plus a small memory-mapped I/O page:
  - free-running cycle counter
  - LED register
  - transmit FIFO with a valid/ready drain port toward an external byte sink
- Reads are combinational (same-cycle readdata); all state updates on rising clk.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
- MMIO_PAGE, 16'hFFFF, value of addr[31:16] selecting the I/O page.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- memwrite  in  1  write strobe from the core's memory stage
- addr  in  32  byte address (aluout); bits[1:0] ignored
- writedata  in  32  store data
- readdata  out  32  load data, combinational from addr
- leds  out  8  LED register contents
- tx_valid  out  1  FIFO head is valid
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  sink accepts head this cycle

Behaviour:
- Decode:
  - MMIO when addr[31:16]==MMIO_PAGE; otherwise RAM at index addr[log2(RAM_WORDS)+1:2]. RAM aliases modulo size.
  - MMIO offsets (addr[15:0]): 0x0000 CYCLE (RO), 0x0004 LED (RW), 0x0008 TXDATA (WO), 0x000C STATUS (RO plus W1C bit).
  - Any other MMIO offset reads 0; writes to it are ignored.
- RAM:
  - Write on posedge when memwrite && RAM selected.
  - Read is combinational, so a read of the word being written in the same cycle returns the old value.
  - RAM is not reset.
- CYCLE: 32-bit counter, +1 every clock, wraps FFFFFFFF->0. Writes are ignored. Reading it returns the current registered value.
- LED: a write stores writedata[7:0]; a read returns {24'b0, leds}.
- TXDATA:
  - A write pushes writedata[7:0] into the FIFO.
  - Push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs in the same cycle.
  - A rejected push drops the byte and sets the sticky ovf bit.
  - Reads of TXDATA return 0.
- Drain:
  - tx_valid = (count!=0); tx_data = head entry.
  - Pop occurs when tx_valid && tx_ready.
  - tx_data must hold stable while tx_valid && !tx_ready.
- STATUS read layout:
  - bit0 full
  - bit1 empty
  - bits[2+:log2(FIFO_DEPTH)+1] count
  - bit8 ovf
  - all other bits 0
- STATUS write: writedata[8]==1 clears ovf. An overflow in the same cycle as the clear wins (ovf stays 1).
- Simultaneous push and pop with count 0: push is stored, no pop occurs (tx_valid was 0); count becomes 1.
- Reset (async assert, sync-safe release): CYCLE=0, leds=0, FIFO count/pointers=0, ovf=0, tx_valid=0, tx_data=0. Reset mid-drain discards queued bytes.
- Latency:
  - Write effects are visible to reads from the next cycle.
  - A pushed byte appears on tx_valid the next cycle.

Decomposition:
- Shared package mem_map_pkg:
  - MMIO_PAGE
  - offsets CYCLE_OFS, LED_OFS, TXDATA_OFS, STATUS_OFS
  - STATUS bit positions
  - a region-select enum {REG_RAM, REG_CYCLE, REG_LED, REG_TX, REG_STATUS, REG_NONE}
- One sub-module: tx_fifo (parameter FIFO_DEPTH).
  - Ports: push, push_data, pop, full, empty, count, head.
  - It implements the pop-frees-slot push rule.
- Top level holds the decode, RAM, CYCLE, LED and ovf logic.

Test Plan:
- RAM: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> 0xDEADBEEF. Read 0x00000110 (alias with RAM_WORDS=64) -> 0xDEADBEEF.
- Reset then CYCLE: release reset, idle 10 clocks, read 0xFFFF0000 -> 10. Assert reset mid-count -> CYCLE, leds, tx_valid go 0 immediately, without a clock edge.
- LED/unmapped: write 0x12345678 to 0xFFFF0004 -> leds=0x78, read returns 0x00000078. Write to 0xFFFF0020 -> no state change; reads return 0.
- FIFO fill/overflow:
  - Setup: tx_ready=0; push 0x41,0x42,0x43,0x44.
  - After the 4th push: STATUS = 0x00000011 (full, count=4). Push 0x45 -> STATUS bit8=1.
  - Write 0x100 to STATUS -> STATUS = 0x00000011.
  - Raise tx_ready -> tx_data 0x41,0x42,0x43,0x44 on consecutive cycles; 0x45 never appears.
- Full with simultaneous push+pop: with count=4 and tx_ready=1, push 0x55 -> accepted, count stays 4, ovf stays 0; 0x55 drains last.
- Backpressure: one byte queued, tx_ready=0 for 5 cycles -> tx_valid=1 and tx_data unchanged throughout. Pop occurs only on the cycle tx_ready=1.
